link_peer_ctrl: RTL and testbench

Sequences the serial link port on behalf of a host-side byte stream, acting as the remote Game Boy. It sits between the link port (its `serial_clk_*`, `serial_data_*` and `sc_*` status) and a bridge-facing byte handshake. When the core clocks a transfer with its internal clock, this block answers as the slave. When the core waits with its external clock and the host has queued a byte, this block generates the 8 clock pulses as the master.

---
 rtl/link_peer_ctrl.sv | 172 +++++++++++++++++
 tb/tb_link_peer_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/link_peer_ctrl.sv
// Link-port peer: answers core-clocked transfers as slave and clocks queued host
// bytes into an externally-clocked core as master, with a one-deep byte handshake each way.
module link_peer_ctrl #(
  parameter int unsigned HALF_PERIOD = 255
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       ce,
  input  logic       sc_start,
  input  logic       sc_int_clock,
  input  logic       serial_clk_out,
  input  logic       serial_data_out,
  output logic       serial_clk_in,
  output logic       serial_data_in,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       rx_overrun,
  output logic       busy
);

  localparam int unsigned HW = 10;
  localparam int unsigned BW = 4;
  localparam logic [HW-1:0] HALF_MAX = HW'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, S_SHIFT, M_LOW, M_HIGH, DONE} state_t;

  state_t        state_q;
  logic          clk_out_q;
  logic          armed_q;
  logic          tx_empty_q;
  logic [7:0]    tx_hold_q;
  logic [7:0]    tx_sh_q;
  logic [7:0]    rx_sh_q;
  logic [BW-1:0] bit_cnt_q;
  logic [HW-1:0] half_cnt_q;
  logic          clk_in_q;
  logic          data_in_q;
  logic          rx_valid_q;
  logic [7:0]    rx_data_q;
  logic          rx_overrun_q;
  logic          busy_q;

  logic rise_c;
  logic abort_c;

  assign rise_c  = ce && serial_clk_out && !clk_out_q;
  // Losing sc_start or flipping clock source mid-byte both end the transfer.
  assign abort_c = !sc_start || (sc_int_clock != (state_q == S_SHIFT));

  assign serial_clk_in  = clk_in_q;
  assign serial_data_in = data_in_q;
  assign tx_ready       = tx_empty_q;
  assign rx_valid       = rx_valid_q;
  assign rx_data        = rx_data_q;
  assign rx_overrun     = rx_overrun_q;
  assign busy           = busy_q;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q      <= IDLE;
      clk_out_q    <= 1'b0;
      armed_q      <= 1'b0;
      tx_empty_q   <= 1'b1;
      tx_hold_q    <= 8'h00;
      tx_sh_q      <= 8'hFF;
      rx_sh_q      <= 8'h00;
      bit_cnt_q    <= '0;
      half_cnt_q   <= '0;
      clk_in_q     <= 1'b0;
      data_in_q    <= 1'b1;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_overrun_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;

      if (ce) begin
        clk_out_q <= serial_clk_out;
        if (!sc_start) armed_q <= 1'b1;

        case (state_q)
          IDLE: begin
            if (sc_start && sc_int_clock && armed_q) begin
              tx_sh_q    <= tx_empty_q ? 8'hFF : tx_hold_q;
              data_in_q  <= tx_empty_q ? 1'b1 : tx_hold_q[7];
              tx_empty_q <= 1'b1;
              bit_cnt_q  <= '0;
              state_q    <= S_SHIFT;
              busy_q     <= 1'b1;
            end else if (sc_start && !sc_int_clock && armed_q && !tx_empty_q) begin
              tx_sh_q    <= tx_hold_q;
              data_in_q  <= tx_hold_q[7];
              tx_empty_q <= 1'b1;
              clk_in_q   <= 1'b0;
              half_cnt_q <= HALF_MAX;
              bit_cnt_q  <= '0;
              state_q    <= M_LOW;
              busy_q     <= 1'b1;
            end
          end

          S_SHIFT, M_LOW, M_HIGH: begin
            if (abort_c) begin
              clk_in_q  <= 1'b0;
              data_in_q <= 1'b1;
              state_q   <= IDLE;
              busy_q    <= 1'b0;
            end else if (state_q == S_SHIFT) begin
              if (rise_c) begin
                rx_sh_q   <= {rx_sh_q[6:0], serial_data_out};
                tx_sh_q   <= {tx_sh_q[6:0], 1'b1};
                data_in_q <= tx_sh_q[6];
                bit_cnt_q <= bit_cnt_q + BW'(1);
                if (bit_cnt_q == BW'(7)) state_q <= DONE;
              end
            end else if (half_cnt_q != '0) begin
              half_cnt_q <= half_cnt_q - HW'(1);
            end else if (state_q == M_LOW) begin
              clk_in_q   <= 1'b1;
              half_cnt_q <= HALF_MAX;
              state_q    <= M_HIGH;
            end else begin
              // End of high phase: sample the core, then drop the clock and present the next bit.
              rx_sh_q   <= {rx_sh_q[6:0], serial_data_out};
              clk_in_q  <= 1'b0;
              tx_sh_q   <= {tx_sh_q[6:0], 1'b1};
              data_in_q <= tx_sh_q[6];
              bit_cnt_q <= bit_cnt_q + BW'(1);
              if (bit_cnt_q == BW'(7)) begin
                state_q <= DONE;
              end else begin
                half_cnt_q <= HALF_MAX;
                state_q    <= M_LOW;
              end
            end
          end

          DONE: begin
            if (!rx_valid_q || rx_ready) begin
              rx_data_q  <= rx_sh_q;
              rx_valid_q <= 1'b1;
            end else begin
              rx_overrun_q <= 1'b1;
            end
            armed_q   <= 1'b0;
            data_in_q <= 1'b1;
            clk_in_q  <= 1'b0;
            state_q   <= IDLE;
            busy_q    <= 1'b0;
          end

          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end

      // Host accept comes last so a byte offered during consumption is kept.
      if (tx_valid && tx_empty_q) begin
        tx_hold_q  <= tx_data;
        tx_empty_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_link_peer_ctrl.sv
// Bench for link_peer_ctrl: a behavioural Game Boy link port drives both clock modes
// while a scoreboard checks every byte the host pops from the rx side.
module tb_link_peer_ctrl;

  localparam int unsigned HP = 4;

  logic       clk_sys = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b0;
  logic       sc_start = 1'b0;
  logic       sc_int_clock = 1'b1;
  logic       serial_clk_out = 1'b1;
  logic       serial_data_out = 1'b1;
  logic       serial_clk_in;
  logic       serial_data_in;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready = 1'b1;
  logic       rx_overrun;
  logic       busy;

  link_peer_ctrl #(.HALF_PERIOD(HP)) dut (
    .clk_sys(clk_sys), .rst(rst), .ce(ce),
    .sc_start(sc_start), .sc_int_clock(sc_int_clock),
    .serial_clk_out(serial_clk_out), .serial_data_out(serial_data_out),
    .serial_clk_in(serial_clk_in), .serial_data_in(serial_data_in),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_overrun(rx_overrun), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;
  always @(negedge clk_sys) ce <= ~ce;

  int unsigned rise_cnt = 0;
  int unsigned hi_cnt = 0;
  logic        prev_ci = 1'b0;

  always @(posedge clk_sys) begin
    prev_ci <= serial_clk_in;
    if (serial_clk_in && !prev_ci) rise_cnt <= rise_cnt + 1;
    if (ce && serial_clk_in) hi_cnt <= hi_cnt + 1;
  end

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] core_sb = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  task automatic wait_ce(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk_sys);
      if (ce) k++;
    end
    #1;
  endtask

  task automatic wait_ci(input logic lvl, input string name);
    int b = 0;
    while (serial_clk_in !== lvl && b < 400) begin
      @(posedge clk_sys);
      #1;
      b++;
    end
    if (serial_clk_in !== lvl) timeout(name);
  endtask

  task automatic host_send(input logic [7:0] b);
    int w = 0;
    while (tx_ready !== 1'b1 && w < 400) begin
      @(posedge clk_sys);
      #1;
      w++;
    end
    if (tx_ready !== 1'b1) timeout("tx_ready");
    tx_valid = 1'b1;
    tx_data  = b;
    @(posedge clk_sys);
    #1;
    tx_valid = 1'b0;
  endtask

  // Core as clock master: data changes on the falling edge, sampled on the rise.
  task automatic core_master(input logic [7:0] sb);
    sc_int_clock   = 1'b1;
    serial_clk_out = 1'b1;
    sc_start       = 1'b0;
    wait_ce(2);
    core_sb  = sb;
    sc_start = 1'b1;
    wait_ce(3);
    for (int i = 0; i < 8; i++) begin
      serial_clk_out  = 1'b0;
      serial_data_out = core_sb[7];
      wait_ce(6);
      serial_clk_out = 1'b1;
      core_sb        = {core_sb[6:0], serial_data_in};
      wait_ce(6);
    end
    wait_ce(2);
    sc_start = 1'b0;
    wait_ce(2);
  endtask

  // Core as clock slave, following serial_clk_in.
  task automatic core_slave_bits(input int n);
    for (int i = 0; i < n; i++) begin
      wait_ci(1'b1, "clk_in_rise");
      core_sb = {core_sb[6:0], serial_data_in};
      wait_ci(1'b0, "clk_in_fall");
      serial_data_out = core_sb[7];
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_clk_in"}, serial_clk_in, 1'b0);
    chk({tag, "_data_in"}, serial_data_in, 1'b1);
    chk({tag, "_tx_ready"}, tx_ready, 1'b1);
    chk({tag, "_rx_valid"}, rx_valid, 1'b0);
    chk({tag, "_rx_data"}, rx_data, 8'h00);
    chk({tag, "_overrun"}, rx_overrun, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int unsigned r0;
    int unsigned h0;

    fork
      forever begin
        logic [7:0] e;
        @(negedge clk_sys);
        if (!rst && rx_valid === 1'b1 && rx_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rx_unexpected: got %02h, none expected", rx_data);
          end else begin
            e = exp_q.pop_front();
            chk("rx_byte", rx_data, e);
          end
        end
      end
    join_none

    repeat (3) @(posedge clk_sys);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    wait_ce(4);

    // Core master with a host byte queued.
    exp_q.push_back(8'hA5);
    host_send(8'h3C);
    core_master(8'hA5);
    chk("cm_core_sb", core_sb, 8'h3C);
    chk("cm_tx_ready", tx_ready, 1'b1);
    chk("cm_busy", busy, 1'b0);

    // Disconnected peer: nothing queued, core sees all ones.
    exp_q.push_back(8'h5A);
    core_master(8'h5A);
    chk("disc_core_sb", core_sb, 8'hFF);
    chk("disc_tx_ready", tx_ready, 1'b1);

    // Core slave: this block generates the clock.
    sc_int_clock = 1'b0;
    sc_start     = 1'b0;
    wait_ce(2);
    r0 = rise_cnt;
    h0 = hi_cnt;
    core_sb         = 8'h81;
    serial_data_out = 1'b1;
    exp_q.push_back(8'h81);
    host_send(8'h7E);
    sc_start = 1'b1;
    core_slave_bits(8);
    wait_ce(4);
    chk("cs_pulses", rise_cnt - r0, 8);
    chk("cs_high_ce", hi_cnt - h0, 8 * HP);
    chk("cs_core_sb", core_sb, 8'h7E);
    chk("cs_busy", busy, 1'b0);

    // No re-clock until sc_start drops and re-rises.
    r0 = rise_cnt;
    host_send(8'h11);
    wait_ce(40);
    chk("rearm_pulses", rise_cnt - r0, 0);
    chk("rearm_tx_held", tx_ready, 1'b0);
    chk("rearm_busy", busy, 1'b0);
    sc_start = 1'b0;
    wait_ce(2);
    core_sb         = 8'hC3;
    serial_data_out = 1'b1;
    exp_q.push_back(8'hC3);
    sc_start = 1'b1;
    core_slave_bits(8);
    wait_ce(4);
    chk("rearm_core_sb", core_sb, 8'h11);
    chk("rearm_pulses2", rise_cnt - r0, 8);
    chk("rearm_tx_ready", tx_ready, 1'b1);

    // Abort after 3 bits in master mode.
    sc_start = 1'b0;
    wait_ce(2);
    host_send(8'h55);
    core_sb         = 8'hF0;
    serial_data_out = 1'b1;
    sc_start        = 1'b1;
    core_slave_bits(3);
    sc_start = 1'b0;
    wait_ce(1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_clk_in", serial_clk_in, 1'b0);
    chk("abort_data_in", serial_data_in, 1'b1);
    wait_ce(4);
    chk("abort_rx_valid", rx_valid, 1'b0);
    chk("abort_tx_ready", tx_ready, 1'b1);

    // Overrun: two bytes with the host stalled.
    rx_ready = 1'b0;
    exp_q.push_back(8'h96);
    core_master(8'h96);
    core_master(8'h69);
    chk("ovr_rx_data", rx_data, 8'h96);
    chk("ovr_rx_valid", rx_valid, 1'b1);
    chk("ovr_flag", rx_overrun, 1'b1);
    rx_ready = 1'b1;
    wait_ce(2);
    chk("ovr_flag_sticky", rx_overrun, 1'b1);

    rst = 1'b1;
    @(posedge clk_sys);
    #1;
    chk_reset_vals("rst2");
    rst = 1'b0;
    wait_ce(2);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
